// File: rtl/pc_gen_unit.sv
// Program-counter generator: next-PC selection, RV32I branch evaluation,
// fetch handshake, stall, trap entry/return with saved EPC and misaligned-target traps.
module pc_gen_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned     IALIGN       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      pc_sel,
  input  logic [2:0]      branch_funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            trap_req,
  input  logic            mret,
  output logic [XLEN-1:0] pc,
  output logic            fetch_valid,
  output logic [XLEN-1:0] link_addr,
  output logic            branch_taken,
  output logic            flush,
  output logic [XLEN-1:0] epc,
  output logic            misalign_exc
);

  localparam logic [XLEN-1:0] STEP       = XLEN'(IALIGN);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_BR   = 2'b01;
  localparam logic [1:0] SEL_JALR = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BUBBLE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_epc;
  logic            r_flush;
  logic            r_misalign;
  logic            r_fetch_valid;

  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_epc_nxt;
  logic            w_flush_nxt;
  logic            w_misalign_nxt;

  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_tgt;
  logic            w_cond;
  logic            w_taken;
  logic            w_misaligned;
  logic            w_advance;

  // Branch condition from the raw operands (no zero flag needed)
  always_comb begin
    w_cond = 1'b0;
    unique case (branch_funct3)
      3'b000:  w_cond = (rs1_val == rs2_val);
      3'b001:  w_cond = (rs1_val != rs2_val);
      3'b100:  w_cond = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  w_cond = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  w_cond = (rs1_val <  rs2_val);
      3'b111:  w_cond = (rs1_val >= rs2_val);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken      = ((pc_sel == SEL_BR) && w_cond) || pc_sel[1];
  assign w_jalr_sum   = rs1_val + imm;
  assign w_tgt        = (pc_sel == SEL_JALR) ? (w_jalr_sum & ~XLEN'(1)) : (r_pc + imm);
  assign w_misaligned = |(w_tgt & ALIGN_MASK);
  assign w_advance    = (r_state == ST_RUN) && fetch_ready && !stall;

  // Next-state and next-PC selection in priority order
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_epc_nxt      = r_epc;
    w_flush_nxt    = 1'b0;
    w_misalign_nxt = 1'b0;
    unique case (r_state)
      ST_BOOT, ST_BUBBLE: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (trap_req) begin
          w_epc_nxt   = r_pc;
          w_pc_nxt    = TRAP_VECTOR;
          w_flush_nxt = 1'b1;
          w_state_nxt = ST_BUBBLE;
        end else if (mret) begin
          w_pc_nxt    = r_epc;
          w_flush_nxt = 1'b1;
        end else if (w_advance && w_taken && w_misaligned) begin
          w_epc_nxt      = r_pc;
          w_pc_nxt       = TRAP_VECTOR;
          w_flush_nxt    = 1'b1;
          w_misalign_nxt = 1'b1;
          w_state_nxt    = ST_BUBBLE;
        end else if (w_advance && w_taken) begin
          w_pc_nxt    = w_tgt;
          w_flush_nxt = 1'b1;
        end else if (w_advance) begin
          w_pc_nxt = r_pc + STEP;
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_VECTOR;
      r_epc         <= '0;
      r_flush       <= 1'b0;
      r_misalign    <= 1'b0;
      r_fetch_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_epc         <= w_epc_nxt;
      r_flush       <= w_flush_nxt;
      r_misalign    <= w_misalign_nxt;
      r_fetch_valid <= (w_state_nxt == ST_RUN);
    end
  end

  assign pc           = r_pc;
  assign epc          = r_epc;
  assign flush        = r_flush;
  assign misalign_exc = r_misalign;
  assign fetch_valid  = r_fetch_valid;
  assign link_addr    = r_pc + STEP;
  assign branch_taken = w_taken;

endmodule
